// File: rtl/adder4_serial_acc_if.sv
// Operand/sum stream bundle for adder4_serial_acc; in_last/out_count exist only
// when ADDER4_SERIAL_LAST_EN is defined.
interface adder4_serial_acc_if #(
   parameter int W     = 8,
   parameter int N_OPS = 4
);
   localparam int SW = W + $clog2(N_OPS);

   // Valid/ready on both streams: a beat transfers on a rising edge where valid
   // and ready are both high; valid and its payload stay stable until then.
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_sum;
   logic          busy;
`ifdef ADDER4_SERIAL_LAST_EN
   logic                     in_last;
   logic [$clog2(N_OPS):0]   out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, busy
   );
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, busy
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, busy
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, busy
   );
`endif
endinterface

// File: rtl/adder4_serial_acc.sv
// Serial accumulator: sums groups of N_OPS unsigned operands into an SW-bit result.
// Optional early group close via in_last when ADDER4_SERIAL_LAST_EN is defined.
module adder4_serial_acc #(
   parameter int W     = 8,
   parameter int N_OPS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   adder4_serial_acc_if.slave   bus,
   output logic [1:0]           state_dbg
);
   localparam int SW = W + $clog2(N_OPS);
   localparam int CW = $clog2(N_OPS);

   if (N_OPS < 2) begin : g_bad_n_ops
      $error("adder4_serial_acc: N_OPS must be >= 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [SW-1:0] acc;
   logic [SW-1:0] sum_reg;
   logic [CW-1:0] count;
   logic [CW:0]   count_p1;
   logic [CW:0]   count_reg;
   logic [SW-1:0] sum_next;
   logic          in_ready_int;
   logic          in_fire;
   logic          last_op;
   logic          close_grp;

`ifdef ADDER4_SERIAL_LAST_EN
   assign last_op = bus.in_last;
`else
   assign last_op = 1'b0;
`endif

   // Datapath decode; a new group starts from zero whenever no partial sum is held.
   always_comb begin
      in_ready_int = (state != OUT) | bus.out_ready;
      in_fire      = bus.in_valid & in_ready_int;
      sum_next     = ((state == ACC) ? acc : '0) + SW'(bus.in_data);
      count_p1     = ((state == ACC) ? {1'b0, count} : '0) + (CW+1)'(1);
      close_grp    = ((state == ACC) && (count == CW'(N_OPS - 1))) | last_op;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_fire) state_next = close_grp ? OUT : ACC;
         ACC:  if (in_fire && close_grp) state_next = OUT;
         OUT: begin
            if (bus.out_ready) begin
               if (in_fire) state_next = close_grp ? OUT : ACC;
               else         state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = in_ready_int;
      bus.out_valid = (state == OUT);
      bus.busy      = (state != IDLE);
      bus.out_sum   = sum_reg;
      state_dbg     = state;
`ifdef ADDER4_SERIAL_LAST_EN
      bus.out_count = count_reg;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         count     <= '0;
         sum_reg   <= '0;
         count_reg <= '0;
      end else if (in_fire) begin
         if (close_grp) begin
            sum_reg   <= sum_next;
            count_reg <= count_p1;
            acc       <= '0;
            count     <= '0;
         end else begin
            acc       <= sum_next;
            count     <= count_p1[CW-1:0];
         end
      end
   end
endmodule

// File: tb/tb_adder4_serial_acc.sv
// Bench for adder4_serial_acc: vector table, multi-cycle corner sequences and a
// randomized run against a group-sum reference model.
module tb_adder4_serial_acc;
   localparam int W     = 8;
   localparam int N_OPS = 4;
   localparam int SW    = W + $clog2(N_OPS);
   localparam int CNTW  = $clog2(N_OPS) + 1;

   typedef struct {
      logic [W-1:0]  op [N_OPS];
      logic [SW-1:0] sum;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] state_dbg;
   int checks = 0;
   int errors = 0;
   bit use_model = 1'b0;
   bit rand_ready = 1'b0;
   logic [SW-1:0] exp_q[$];
   int grp[$];
`ifdef ADDER4_SERIAL_LAST_EN
   logic [CNTW-1:0] exp_cnt_q[$];
`endif

   always #5 clk = ~clk;

   adder4_serial_acc_if #(.W(W), .N_OPS(N_OPS)) bus ();

   adder4_serial_acc #(.W(W), .N_OPS(N_OPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_sum(input logic [SW-1:0] s, input int cnt = N_OPS);
      exp_q.push_back(s);
`ifdef ADDER4_SERIAL_LAST_EN
      exp_cnt_q.push_back(CNTW'(cnt));
`else
      if (cnt != N_OPS) $display("note: group count %0d ignored", cnt);
`endif
   endtask

   // Called at posedge+1; returns at posedge+1 of the edge that accepted the operand.
   task automatic send_op(input logic [W-1:0] d, input bit lst = 1'b0);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
`ifdef ADDER4_SERIAL_LAST_EN
      bus.in_last  = lst;
`else
      if (lst) $display("note: in_last not built");
`endif
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("accept_timeout", 32'(t >= 100), 32'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 'x;
`ifdef ADDER4_SERIAL_LAST_EN
      bus.in_last  = 1'b0;
`endif
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard on the output stream plus the reference model on the input stream.
   always @(negedge clk) begin
      int  s;
      bit  lst;
      if (!rst_n) begin
         grp.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_sum: got %0d expected none", bus.out_sum);
            end else begin
               check("out_sum", bus.out_sum, exp_q.pop_front());
            end
`ifdef ADDER4_SERIAL_LAST_EN
            if (exp_cnt_q.size() != 0) check("out_count", bus.out_count, exp_cnt_q.pop_front());
`endif
         end
         if (use_model && bus.in_valid && bus.in_ready) begin
            lst = 1'b0;
`ifdef ADDER4_SERIAL_LAST_EN
            lst = bus.in_last;
`endif
            grp.push_back(int'(bus.in_data));
            if (grp.size() == N_OPS || lst) begin
               s = 0;
               foreach (grp[i]) s += grp[i];
               expect_sum(SW'(s), grp.size());
               grp.delete();
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[5];
      vecs[0].op = '{8'd1, 8'd2, 8'd3, 8'd4};         vecs[0].sum = 10'd10;
      vecs[1].op = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};     vecs[1].sum = 10'h3FC;
      vecs[2].op = '{8'd0, 8'd0, 8'd0, 8'd0};         vecs[2].sum = 10'd0;
      vecs[3].op = '{8'd255, 8'd0, 8'd255, 8'd0};     vecs[3].sum = 10'd510;
      vecs[4].op = '{8'd128, 8'd64, 8'd32, 8'd200};   vecs[4].sum = 10'd424;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef ADDER4_SERIAL_LAST_EN
      bus.in_last   = 1'b0;
`endif

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: sum visible the cycle after the fourth accept, idle afterwards
      expect_sum(10'd10);
      send_op(8'd1);
      send_op(8'd2);
      send_op(8'd3);
      send_op(8'd4);
      @(negedge clk);
      check("lat_out_valid", bus.out_valid, 1);
      check("lat_busy", bus.busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_out_valid", bus.out_valid, 0);
      check("post_busy", bus.busy, 0);
      @(posedge clk);
      #1;

      // Vector table
      for (int i = 0; i < 5; i++) begin
         expect_sum(vecs[i].sum);
         for (int j = 0; j < N_OPS; j++) send_op(vecs[i].op[j]);
         wait_drain();
      end

      // Output stall, then release with the next group's first operand
      expect_sum(10'd100);
      expect_sum(10'd4);
      bus.out_ready = 1'b0;
      send_op(8'd10);
      send_op(8'd20);
      send_op(8'd30);
      send_op(8'd40);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd1;
      repeat (5) begin
         @(negedge clk);
         check("stall_out_valid", bus.out_valid, 1);
         check("stall_out_sum", bus.out_sum, 100);
         check("stall_in_ready", bus.in_ready, 0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", bus.in_ready, 1);
      check("release_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      send_op(8'd1);
      send_op(8'd1);
      send_op(8'd1);
      wait_drain();

      // Sustained throughput across three groups
      use_model = 1'b1;
      for (int k = 0; k < 3 * N_OPS; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = W'($urandom_range(0, 255));
         @(negedge clk);
         check("tp_in_ready", bus.in_ready, 1);
         check("tp_out_valid", bus.out_valid, 32'(k != 0 && k % N_OPS == 0));
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      wait_drain();

      // Reset mid-group discards the partial sum
      send_op(8'd5);
      send_op(8'd6);
      send_op(8'd7);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_out_sum", bus.out_sum, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int j = 0; j < N_OPS; j++) send_op(8'd1);
      wait_drain();

      // Randomized traffic with random consumer backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 200; n++) begin
         send_op(W'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      wait_drain();
      use_model = 1'b0;

`ifdef ADDER4_SERIAL_LAST_EN
      // Early close via in_last, then a full group
      expect_sum(10'd17, 2);
      send_op(8'd9);
      send_op(8'd8, 1'b1);
      wait_drain();
      expect_sum(10'd10, 4);
      send_op(8'd1);
      send_op(8'd2);
      send_op(8'd3);
      send_op(8'd4);
      wait_drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder4_serial_acc.md
Name: adder4_serial_acc

Overview:
- Sequential counterpart of the team's combinational four-operand adder.
- Accepts 8-bit operands one per beat on a valid/ready input stream, accumulates a group of N_OPS operands, and emits the widened sum on a valid/ready output stream.
- Sits between an operand producer (FIFO or serializer) and the datapath consumer of the final sum; width rules match the combinational version (4 x 8-bit -> 10-bit).

Parameters:
- W, 8, operand width in bits
- N_OPS, 4, operands per group; must be >= 2
- SW, W+$clog2(N_OPS), sum width (10 at defaults); derived, not overridden

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  block accepts operand this cycle
- in_data  input  W  unsigned operand
- out_valid  output  1  group sum available
- out_ready  input  1  consumer accepts sum
- out_sum  output  SW  unsigned sum of the group
- busy  output  1  group partially accumulated (count != 0) or sum pending

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, acc=0, count=0
  - out_valid=0, out_sum=0, busy=0; in_ready=1 after reset release.
- States:
  - IDLE: no operands held.
  - ACC: 1..N_OPS-1 operands accepted.
  - OUT: sum held on out_sum with out_valid=1.
- Accept: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != OUT) | out_ready, combinational from state and out_ready only.
- On in_fire in IDLE, or in OUT with out_fire:
  - acc <= zero-extended in_data, count <= 1, state <= ACC.
  - If N_OPS == 1 is ever permitted, it is rejected by elaboration check; N_OPS >= 2 is required.
- On in_fire in ACC with count < N_OPS-1: acc <= acc + in_data (SW-bit add), count++.
- On in_fire in ACC with count == N_OPS-1:
  - out_sum <= acc + in_data, out_valid <= 1, count <= 0, state <= OUT.
- Latency: out_valid asserts the cycle after the Nth operand is accepted.
- Throughput: one operand per cycle sustained with out_ready=1; no bubble between groups.
- OUT with out_fire and no in_fire: out_valid <= 0, state <= IDLE.
- OUT without out_ready:
  - out_sum and out_valid held stable; in_ready=0; no operand lost.
- in_valid low in ACC: partial sum held indefinitely; no timeout.
- Arithmetic:
  - Unsigned; SW bits cannot overflow (max N_OPS*(2^W-1) < 2^SW).
  - Defaults: max 1020 = 10'h3FC.
- Reset mid-group or with sum pending: partial accumulation and pending sum discarded, all outputs return to reset values immediately.
- in_data is ignored when in_valid=0; X on in_data with in_valid=0 must not propagate.

Optional Feature:
- Macro: ADDER4_SERIAL_LAST_EN
- Defined:
  - Adds input port in_last (1 bit), sampled on in_fire.
  - An operand with in_last=1 closes the group early: out_sum <= acc + in_data (or in_data alone if first), state <= OUT, count <= 0.
  - in_last on the Nth operand behaves as a normal completion.
  - Adds output out_count ($clog2(N_OPS)+1 bits): number of operands in the emitted group, valid with out_valid.
- Not defined: no in_last/out_count ports; groups are always exactly N_OPS operands.

Test Plan:
- Reset, then operands 1,2,3,4 back-to-back with out_ready=1 -> out_valid one cycle after 4th accept, out_sum=10, busy low afterwards.
- Four operands of 8'hFF -> out_sum=10'h3FC; no truncation.
- Groups {10,20,30,40} then {1,1,1,1} with out_ready=0 for 5 cycles after the first sum:
  - out_sum=100 held stable, in_ready=0 throughout the stall.
  - On release, the first operand of the second group is accepted in the same cycle as out_fire; second out_sum=4.
- Continuous in_valid=1 and out_ready=1 over 3 groups -> in_ready never drops; out_valid pulses every 4 cycles.
- Accept 5,6,7, assert rst_n=0 for 1 cycle, then send 1,1,1,1 -> out_sum=4 (partial 18 discarded); outputs zero during reset.
- With ADDER4_SERIAL_LAST_EN: operands 9,8 with in_last on 8 -> out_sum=17, out_count=2; a following full group 1,2,3,4 -> 10, out_count=4.
